hpdcache_cmo_req_if: RTL and testbench

HPDCACHE_CMO_REQ_IF -- requirements
Module: hpdcache_cmo_req_if

---
 rtl/hpdcache_pkg.sv | 24 ++
 rtl/hpdcache_cmo_op_decode.sv | 22 ++
 rtl/hpdcache_cmo_req_if.sv | 140 ++++++++++++++
 tb/tb_hpdcache_cmo_req_if.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_pkg.sv
// Shared CMO request-interface definitions: opcodes, one-hot op struct, FSM states.
package hpdcache_pkg;

  localparam logic [3:0] CMO_OP_FENCE         = 4'h8;
  localparam logic [3:0] CMO_OP_INVAL_NLINE   = 4'h9;
  localparam logic [3:0] CMO_OP_INVAL_SET_WAY = 4'hA;
  localparam logic [3:0] CMO_OP_INVAL_ALL     = 4'hB;

  // Bit order matches the handler's op vector: [0] fence ... [3] inval_nline.
  typedef struct packed {
    logic inval_nline;
    logic inval_set_way;
    logic inval_all;
    logic fence;
  } cmo_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy,
    StRsp
  } cmo_state_e;

endpackage

// File: rtl/hpdcache_cmo_op_decode.sv
// Combinational CMO opcode decoder: raw 4-bit opcode to one-hot op plus legality flag.
module hpdcache_cmo_op_decode
  import hpdcache_pkg::*;
(
  input  logic [3:0] i_op,
  output cmo_op_t    o_op,
  output logic       o_legal
);

  always_comb begin
    o_op    = '0;
    o_legal = 1'b1;
    unique case (i_op)
      CMO_OP_FENCE:         o_op.fence         = 1'b1;
      CMO_OP_INVAL_NLINE:   o_op.inval_nline   = 1'b1;
      CMO_OP_INVAL_SET_WAY: o_op.inval_set_way = 1'b1;
      CMO_OP_INVAL_ALL:     o_op.inval_all     = 1'b1;
      default:              o_legal            = 1'b0;
    endcase
  end

endmodule

// File: rtl/hpdcache_cmo_req_if.sv
// Core-side CMO request interface: accepts one CMO, issues it to the handler, waits for
// completion and optionally responds. Define HPDCACHE_CMO_ERR_RSP_EN to answer illegal ops.
module hpdcache_cmo_req_if
  import hpdcache_pkg::*;
#(
  parameter int unsigned ADDR_W = 49,
  parameter int unsigned WORD_W = 64,
  parameter int unsigned WAYS   = 8,
  parameter int unsigned SID_W  = 3,
  parameter int unsigned TID_W  = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_valid_i,
  output logic              core_req_ready_o,
  input  logic [3:0]        core_req_op_i,
  input  logic [ADDR_W-1:0] core_req_addr_i,
  input  logic [WORD_W-1:0] core_req_wdata_i,
  input  logic [SID_W-1:0]  core_req_sid_i,
  input  logic [TID_W-1:0]  core_req_tid_i,
  input  logic              core_req_need_rsp_i,
  output logic              cmo_req_valid_o,
  input  logic              cmo_req_ready_i,
  input  logic              cmo_req_wait_i,
  output logic [3:0]        cmo_req_op_o,
  output logic [ADDR_W-1:0] cmo_req_addr_o,
  output logic [WORD_W-1:0] cmo_req_wdata_o,
  output logic              core_rsp_valid_o,
  input  logic              core_rsp_ready_i,
  output logic [SID_W-1:0]  core_rsp_sid_o,
  output logic [TID_W-1:0]  core_rsp_tid_o,
  output logic              core_rsp_error_o,
  output logic [15:0]       cmo_done_cnt_o
);

`ifdef HPDCACHE_CMO_ERR_RSP_EN
  localparam bit ErrRspEn = 1'b1;
`else
  localparam bit ErrRspEn = 1'b0;
`endif

  cmo_state_e        r_state;
  cmo_op_t           r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [SID_W-1:0]  r_sid;
  logic [TID_W-1:0]  r_tid;
  logic              r_need_rsp;
  logic [15:0]       r_done_cnt;

  cmo_op_t w_dec_op;
  logic    w_dec_legal;
  logic    w_core_hs;
  logic    w_op_active;
  logic    w_unused;

  hpdcache_cmo_op_decode u_op_decode (
    .i_op    (core_req_op_i),
    .o_op    (w_dec_op),
    .o_legal (w_dec_legal)
  );

  assign w_core_hs   = core_req_valid_i && (r_state == StIdle);
  assign w_op_active = (r_state == StIssue) || (r_state == StBusy);

  // Wait is informational only; the way vector lives in the low WAYS bits of wdata.
  assign w_unused = ^{cmo_req_wait_i, core_req_wdata_i[WAYS-1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_done_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (core_req_valid_i) begin
            if (w_dec_legal) begin
              r_state <= StIssue;
            end else if (ErrRspEn) begin
              r_state <= StRsp;
            end
          end
        end
        StIssue: begin
          if (cmo_req_ready_i) r_state <= StBusy;
        end
        // Ready is only trusted from the first BUSY cycle on, never in the issue cycle.
        StBusy: begin
          if (cmo_req_ready_i) begin
            r_done_cnt <= r_done_cnt + 16'd1;
            r_state    <= r_need_rsp ? StRsp : StIdle;
          end
        end
        StRsp: begin
          if (core_rsp_ready_i) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Payload is qualified by state everywhere it is visible, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_core_hs) begin
      r_op       <= w_dec_op;
      r_addr     <= core_req_addr_i;
      r_wdata    <= core_req_wdata_i;
      r_sid      <= core_req_sid_i;
      r_tid      <= core_req_tid_i;
      r_need_rsp <= core_req_need_rsp_i;
    end
  end

`ifdef HPDCACHE_CMO_ERR_RSP_EN
  logic r_rsp_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_err <= 1'b0;
    end else if (w_core_hs) begin
      r_rsp_err <= ~w_dec_legal;
    end
  end

  assign core_rsp_error_o = r_rsp_err && (r_state == StRsp);
`else
  assign core_rsp_error_o = 1'b0;
`endif

  assign core_req_ready_o = (r_state == StIdle);
  assign cmo_req_valid_o  = (r_state == StIssue);
  assign cmo_req_op_o     = r_op & {4{w_op_active}};
  assign cmo_req_addr_o   = r_addr;
  assign cmo_req_wdata_o  = r_wdata;
  assign core_rsp_valid_o = (r_state == StRsp);
  assign core_rsp_sid_o   = r_sid;
  assign core_rsp_tid_o   = r_tid;
  assign cmo_done_cnt_o   = r_done_cnt;

endmodule

// File: tb/tb_hpdcache_cmo_req_if.sv
// Self-checking bench for hpdcache_cmo_req_if: directed scenarios plus random transactions
// checked against a transaction-level expectation model.
module tb_hpdcache_cmo_req_if;

  localparam int unsigned ADDR_W = 49;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned WAYS   = 8;
  localparam int unsigned SID_W  = 3;
  localparam int unsigned TID_W  = 7;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              core_req_valid_i;
  logic              core_req_ready_o;
  logic [3:0]        core_req_op_i;
  logic [ADDR_W-1:0] core_req_addr_i;
  logic [WORD_W-1:0] core_req_wdata_i;
  logic [SID_W-1:0]  core_req_sid_i;
  logic [TID_W-1:0]  core_req_tid_i;
  logic              core_req_need_rsp_i;
  logic              cmo_req_valid_o;
  logic              cmo_req_ready_i;
  logic              cmo_req_wait_i;
  logic [3:0]        cmo_req_op_o;
  logic [ADDR_W-1:0] cmo_req_addr_o;
  logic [WORD_W-1:0] cmo_req_wdata_o;
  logic              core_rsp_valid_o;
  logic              core_rsp_ready_i;
  logic [SID_W-1:0]  core_rsp_sid_o;
  logic [TID_W-1:0]  core_rsp_tid_o;
  logic              core_rsp_error_o;
  logic [15:0]       cmo_done_cnt_o;

  hpdcache_cmo_req_if #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W),
    .WAYS   (WAYS),
    .SID_W  (SID_W),
    .TID_W  (TID_W)
  ) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .core_req_valid_i    (core_req_valid_i),
    .core_req_ready_o    (core_req_ready_o),
    .core_req_op_i       (core_req_op_i),
    .core_req_addr_i     (core_req_addr_i),
    .core_req_wdata_i    (core_req_wdata_i),
    .core_req_sid_i      (core_req_sid_i),
    .core_req_tid_i      (core_req_tid_i),
    .core_req_need_rsp_i (core_req_need_rsp_i),
    .cmo_req_valid_o     (cmo_req_valid_o),
    .cmo_req_ready_i     (cmo_req_ready_i),
    .cmo_req_wait_i      (cmo_req_wait_i),
    .cmo_req_op_o        (cmo_req_op_o),
    .cmo_req_addr_o      (cmo_req_addr_o),
    .cmo_req_wdata_o     (cmo_req_wdata_o),
    .core_rsp_valid_o    (core_rsp_valid_o),
    .core_rsp_ready_i    (core_rsp_ready_i),
    .core_rsp_sid_o      (core_rsp_sid_o),
    .core_rsp_tid_o      (core_rsp_tid_o),
    .core_rsp_error_o    (core_rsp_error_o),
    .cmo_done_cnt_o      (cmo_done_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] m_cnt = 16'd0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Handler op vector: [0] fence, [1] inval_all, [2] inval_set_way, [3] inval_nline.
  function automatic logic [3:0] exp_onehot(input logic [3:0] op);
    case (op)
      4'h8:    return 4'b0001;
      4'h9:    return 4'b1000;
      4'hA:    return 4'b0100;
      4'hB:    return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [63:0] r64;
    r64 = {$urandom, $urandom};
    return r64[ADDR_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] rand_word();
    logic [63:0] r64;
    r64 = {$urandom, $urandom};
    return r64[WORD_W-1:0];
  endfunction

  // Random payload on the core side while the DUT should be ignoring it.
  task automatic scramble_core_inputs();
    core_req_op_i       = 4'($urandom_range(8, 11));
    core_req_addr_i     = rand_addr();
    core_req_wdata_i    = rand_word();
    core_req_sid_i      = SID_W'($urandom);
    core_req_tid_i      = TID_W'($urandom);
    core_req_need_rsp_i = 1'($urandom);
  endtask

  task automatic run_txn(input logic [3:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [WORD_W-1:0] wdata, input logic [SID_W-1:0] sid,
                         input logic [TID_W-1:0] tid, input logic need_rsp,
                         input int s_issue, input int s_busy, input int s_rsp);
    logic [3:0] oh;
    logic       legal;
    logic       gives_rsp;
    logic       exp_err;
    int         t_acc;
    int         exp_lat;
    oh        = exp_onehot(op);
    legal     = (oh != 4'b0);
    gives_rsp = 1'b0;
    exp_err   = 1'b0;
    exp_lat   = 0;

    check_eq("idle_ready", 64'(core_req_ready_o), 64'(1));
    core_req_valid_i    = 1'b1;
    core_req_op_i       = op;
    core_req_addr_i     = addr;
    core_req_wdata_i    = wdata;
    core_req_sid_i      = sid;
    core_req_tid_i      = tid;
    core_req_need_rsp_i = need_rsp;
    tick();
    t_acc = cyc;
    core_req_valid_i = 1'b0;
    scramble_core_inputs();

    if (!legal) begin
      check_eq("illegal_no_issue", 64'(cmo_req_valid_o), 64'(0));
`ifdef HPDCACHE_CMO_ERR_RSP_EN
      gives_rsp = 1'b1;
      exp_err   = 1'b1;
`else
      check_eq("illegal_drop_ready", 64'(core_req_ready_o), 64'(1));
      check_eq("illegal_drop_rsp", 64'(core_rsp_valid_o), 64'(0));
`endif
    end else begin
      for (int i = 0; i <= s_issue; i++) begin
        check_eq("issue_valid", 64'(cmo_req_valid_o), 64'(1));
        check_eq("issue_op", 64'(cmo_req_op_o), 64'(oh));
        check_eq("issue_addr", 64'(cmo_req_addr_o), 64'(addr));
        check_eq("issue_wdata", 64'(cmo_req_wdata_o), 64'(wdata));
        check_eq("issue_core_ready", 64'(core_req_ready_o), 64'(0));
        cmo_req_ready_i = (i == s_issue);
        tick();
      end
      for (int i = 0; i <= s_busy; i++) begin
        check_eq("busy_valid", 64'(cmo_req_valid_o), 64'(0));
        check_eq("busy_op", 64'(cmo_req_op_o), 64'(oh));
        check_eq("busy_rsp_valid", 64'(core_rsp_valid_o), 64'(0));
        check_eq("busy_cnt", 64'(cmo_done_cnt_o), 64'(m_cnt));
        cmo_req_ready_i = (i == s_busy);
        tick();
      end
      cmo_req_ready_i = 1'($urandom);
      m_cnt     = m_cnt + 16'd1;
      gives_rsp = need_rsp;
      exp_lat   = 2 + s_issue + s_busy;
    end

    if (gives_rsp) begin
      check_eq("rsp_latency", 64'(cyc - t_acc), 64'(exp_lat));
      for (int i = 0; i <= s_rsp; i++) begin
        check_eq("rsp_valid", 64'(core_rsp_valid_o), 64'(1));
        check_eq("rsp_sid", 64'(core_rsp_sid_o), 64'(sid));
        check_eq("rsp_tid", 64'(core_rsp_tid_o), 64'(tid));
        check_eq("rsp_error", 64'(core_rsp_error_o), 64'(exp_err));
        check_eq("rsp_core_ready", 64'(core_req_ready_o), 64'(0));
        check_eq("rsp_cmo_valid", 64'(cmo_req_valid_o), 64'(0));
        check_eq("rsp_op_zero", 64'(cmo_req_op_o), 64'(0));
        // A new request waits behind the pending response, even on the release cycle.
        scramble_core_inputs();
        core_req_valid_i = 1'b1;
        core_rsp_ready_i = (i == s_rsp);
        tick();
      end
      core_rsp_ready_i = 1'b0;
      check_eq("post_rsp_ready", 64'(core_req_ready_o), 64'(1));
      check_eq("post_rsp_no_issue", 64'(cmo_req_valid_o), 64'(0));
      core_req_valid_i = 1'b0;
    end else begin
      check_eq("done_ready", 64'(core_req_ready_o), 64'(1));
    end
    check_eq("done_rsp_valid", 64'(core_rsp_valid_o), 64'(0));
    check_eq("done_cnt", 64'(cmo_done_cnt_o), 64'(m_cnt));
  endtask

  task automatic check_idle_after_reset(input string tag);
    check_eq({tag, "_ready"}, 64'(core_req_ready_o), 64'(1));
    check_eq({tag, "_cmo_valid"}, 64'(cmo_req_valid_o), 64'(0));
    check_eq({tag, "_op"}, 64'(cmo_req_op_o), 64'(0));
    check_eq({tag, "_rsp_valid"}, 64'(core_rsp_valid_o), 64'(0));
    check_eq({tag, "_error"}, 64'(core_rsp_error_o), 64'(0));
    check_eq({tag, "_cnt"}, 64'(cmo_done_cnt_o), 64'(0));
  endtask

  task automatic reset_during_busy();
    core_req_valid_i    = 1'b1;
    core_req_op_i       = 4'hB;
    core_req_addr_i     = rand_addr();
    core_req_wdata_i    = rand_word();
    core_req_sid_i      = 3'd2;
    core_req_tid_i      = 7'd9;
    core_req_need_rsp_i = 1'b1;
    tick();
    core_req_valid_i = 1'b0;
    cmo_req_ready_i  = 1'b1;
    tick();
    check_eq("rstbusy_op", 64'(cmo_req_op_o), 64'(4'b0010));
    cmo_req_ready_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i  = 1'b0;
    m_cnt  = 16'd0;
    check_idle_after_reset("rstbusy");
    cmo_req_ready_i = 1'b1;
    tick();
    tick();
    check_eq("rstbusy_no_rsp", 64'(core_rsp_valid_o), 64'(0));
    check_eq("rstbusy_no_cnt", 64'(cmo_done_cnt_o), 64'(0));
  endtask

  initial begin
    logic [3:0] op;
    rst_i               = 1'b1;
    core_req_valid_i    = 1'b0;
    core_req_op_i       = 4'h0;
    core_req_addr_i     = '0;
    core_req_wdata_i    = '0;
    core_req_sid_i      = '0;
    core_req_tid_i      = '0;
    core_req_need_rsp_i = 1'b0;
    cmo_req_ready_i     = 1'b0;
    cmo_req_wait_i      = 1'b0;
    core_rsp_ready_i    = 1'b0;
    tick();
    tick();
    check_idle_after_reset("reset");
    rst_i = 1'b0;
    tick();

    // Fence with the handler always ready: issue T+1, one BUSY cycle, response T+3.
    run_txn(4'h8, rand_addr(), rand_word(), 3'd1, 7'h11, 1'b1, 0, 0, 0);
    // Line invalidate, handler not ready for 3 cycles of BUSY.
    run_txn(4'h9, 49'h1000, rand_word(), 3'd6, 7'h5A, 1'b1, 0, 3, 0);
    // Illegal opcode with and without a response request.
    run_txn(4'h3, rand_addr(), rand_word(), 3'd3, 7'h22, 1'b0, 0, 0, 0);
    run_txn(4'h3, rand_addr(), rand_word(), 3'd4, 7'h33, 1'b1, 0, 0, 2);
    // Response held off for 5 cycles.
    run_txn(4'hA, rand_addr(), rand_word(), 3'd5, 7'h44, 1'b1, 1, 0, 5);
    // Set/way invalidate without response.
    run_txn(4'hA, rand_addr(), rand_word(), 3'd7, 7'h01, 1'b0, 2, 1, 0);

    reset_during_busy();

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) < 4) op = 4'($urandom_range(8, 11));
      else                          op = 4'($urandom_range(0, 15));
      run_txn(op, rand_addr(), rand_word(), SID_W'($urandom), TID_W'($urandom),
              1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Counter wrap: start from 16'hFFFF, two completions must land on 1.
    dut.r_done_cnt = 16'hFFFF;
    m_cnt          = 16'hFFFF;
    #1;
    check_eq("cnt_preload", 64'(cmo_done_cnt_o), 64'(16'hFFFF));
    run_txn(4'h8, rand_addr(), rand_word(), 3'd0, 7'h7F, 1'b0, 0, 0, 0);
    run_txn(4'hB, rand_addr(), rand_word(), 3'd2, 7'h0C, 1'b1, 1, 2, 1);
    check_eq("cnt_wrap", 64'(cmo_done_cnt_o), 64'(16'h0001));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
